// File: rtl/seg_pkg.sv
// Shared types for the 7-segment scan controller: nibble width, scan states, nibble type.
package seg_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {S_OFF, S_DWELL, S_GUARD} scan_state_t;
   typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable up-counter with terminal-count compare; clr_i reloads zero on the next edge.
// tc_o is combinational on the current count against the limit chosen by the caller.
module seg_dwell_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else            cnt_q <= cnt_q + 1'b1;
   end

   assign tc_o = (cnt_q == limit_i);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit common-anode 7-segment scan controller with frame-boundary data update.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 50000,
   parameter int GUARD_CYC  = 500
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [4*NUM_DIGITS-1:0]    load_data,
   input  logic [NUM_DIGITS-1:0]      load_dp,
   output logic [NIBBLE_W-1:0]        digit_val,
   output logic                       dp,
   output logic [NUM_DIGITS-1:0]      an_n,
   output logic                       frame_done
);
   localparam int MAXC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
   localparam int TW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam logic [TW-1:0] DW_LIM = TW'(DWELL_CYC - 1);
   localparam logic [TW-1:0] GD_LIM = TW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
   localparam logic [IW-1:0] LAST   = IW'(NUM_DIGITS - 1);

   scan_state_t                    state_q, state_d;
   logic [IW-1:0]                  idx_q, idx_d;
   nibble_t [NUM_DIGITS-1:0]       act_dat_q, act_dat_d, pend_dat_q, pend_dat_d;
   logic [NUM_DIGITS-1:0]          act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                           pend_vld_q, pend_vld_d;
   logic                           ready_q, ready_d;
   logic                           fdone_q, fdone_d;
   logic [NUM_DIGITS-1:0]          an_n_q, an_n_d;
   nibble_t                        digit_q, digit_d;
   logic                           dp_q, dp_d;
   logic [NUM_DIGITS-1:0]          blank;
   logic                           accept, digit_adv, wrap;
   logic                           tmr_clr, tmr_tc;
   logic [TW-1:0]                  tmr_lim;

   assign accept  = load_valid && ready_q;
   assign tmr_lim = (state_q == S_GUARD) ? GD_LIM : DW_LIM;
   assign tmr_clr = !enable || (state_q == S_OFF) || tmr_tc;

   seg_dwell_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (tmr_clr),
      .limit_i (tmr_lim),
      .tc_o    (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      act_dat_d  = act_dat_q;
      act_dp_d   = act_dp_q;
      pend_dat_d = pend_dat_q;
      pend_dp_d  = pend_dp_q;
      pend_vld_d = pend_vld_q;
      fdone_d    = 1'b0;
      digit_adv  = 1'b0;
      if (accept) begin
         pend_vld_d = 1'b1;
         pend_dat_d = load_data;
         pend_dp_d  = load_dp;
      end
      if (!enable) begin
         state_d = S_OFF;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_DWELL;
               idx_d   = '0;
            end
            S_DWELL: if (tmr_tc) begin
               if (GUARD_CYC == 0) digit_adv = 1'b1;
               else                state_d   = S_GUARD;
            end
            S_GUARD: if (tmr_tc) digit_adv = 1'b1;
            default: state_d = S_OFF;
         endcase
      end
      wrap = digit_adv && (idx_q == LAST);
      if (digit_adv) begin
         state_d = S_DWELL;
         idx_d   = wrap ? '0 : idx_q + 1'b1;
         fdone_d = wrap;
      end
      // Accept needs an empty pending buffer, so it can never collide with a copy.
      if ((state_q == S_OFF || wrap) && pend_vld_q) begin
         act_dat_d  = pend_dat_q;
         act_dp_d   = pend_dp_q;
         pend_vld_d = 1'b0;
      end
      ready_d = !pend_vld_d && !pend_vld_q;
   end

`ifdef SEG_LZ_BLANK_EN
   always_comb begin
      logic hz;
      hz    = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         blank[i] = hz && (act_dat_d[i] == '0) && !act_dp_d[i] && (i != 0);
         hz       = hz && (act_dat_d[i] == '0);
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      an_n_d  = '1;
      digit_d = digit_q;
      dp_d    = dp_q;
      if (state_d == S_DWELL) begin
         digit_d = act_dat_d[idx_d];
         dp_d    = act_dp_d[idx_d];
         if (!blank[idx_d]) an_n_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         idx_q      <= '0;
         act_dat_q  <= '0;
         act_dp_q   <= '0;
         pend_dat_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
         ready_q    <= 1'b1;
         fdone_q    <= 1'b0;
         an_n_q     <= '1;
         digit_q    <= '0;
         dp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         act_dat_q  <= act_dat_d;
         act_dp_q   <= act_dp_d;
         pend_dat_q <= pend_dat_d;
         pend_dp_q  <= pend_dp_d;
         pend_vld_q <= pend_vld_d;
         ready_q    <= ready_d;
         fdone_q    <= fdone_d;
         an_n_q     <= an_n_d;
         digit_q    <= digit_d;
         dp_q       <= dp_d;
      end
   end

   assign load_ready = ready_q;
   assign frame_done = fdone_q;
   assign an_n       = an_n_q;
   assign digit_val  = digit_q;
   assign dp         = dp_q;
endmodule
